// File: rtl/address_sequencer_if.sv
// Operation/status bundle between the microcode controller and the next-address sequencer.
// The sequencer takes the slave modport; whoever drives Mode/Enable/target takes master.
interface address_sequencer_if #(
    parameter int ADDR_WIDTH  = 11,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1);

    logic                   ADDRSEQ_Enable_IN;
    logic [2:0]             ADDRSEQ_Mode_IN;
    logic                   ADDRSEQ_Cond_IN;
    logic [ADDR_WIDTH-1:0]  ADDRSEQ_Direccion_IN;
    logic [ADDR_WIDTH-1:0]  ADDRSEQ_Direccion_OUT;
    logic [DEPTH_WIDTH-1:0] ADDRSEQ_Depth_OUT;
    logic                   ADDRSEQ_StackFull_OUT;
    logic                   ADDRSEQ_StackEmpty_OUT;
    logic                   ADDRSEQ_Error_OUT;

    modport master (
        output ADDRSEQ_Enable_IN, ADDRSEQ_Mode_IN, ADDRSEQ_Cond_IN, ADDRSEQ_Direccion_IN,
        input  ADDRSEQ_Direccion_OUT, ADDRSEQ_Depth_OUT, ADDRSEQ_StackFull_OUT,
               ADDRSEQ_StackEmpty_OUT, ADDRSEQ_Error_OUT
    );

    modport slave (
        input  ADDRSEQ_Enable_IN, ADDRSEQ_Mode_IN, ADDRSEQ_Cond_IN, ADDRSEQ_Direccion_IN,
        output ADDRSEQ_Direccion_OUT, ADDRSEQ_Depth_OUT, ADDRSEQ_StackFull_OUT,
               ADDRSEQ_StackEmpty_OUT, ADDRSEQ_Error_OUT
    );
endinterface

// File: rtl/address_sequencer.sv
// Next-address sequencer for the microprogrammed datapath: eight sequencing modes
// with a return-address stack for CALL/RET and a sticky over/underflow flag.
module address_sequencer #(
    parameter int              ADDR_WIDTH  = 11,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic               ADDRSEQ_CLOCK_50,
    input  logic               ADDRSEQ_RESET_InHigh,
    address_sequencer_if.slave bus
);
    localparam int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1);
    localparam int IDX_WIDTH   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = DEPTH_WIDTH'(STACK_DEPTH);

    typedef enum logic [2:0] {
        MODE_INC     = 3'b000,
        MODE_JMP     = 3'b001,
        MODE_JCT     = 3'b010,
        MODE_JCF     = 3'b011,
        MODE_CALL    = 3'b100,
        MODE_RET     = 3'b101,
        MODE_HOLD    = 3'b110,
        MODE_RESTART = 3'b111
    } mode_t;

    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [DEPTH_WIDTH-1:0] depth_reg;
    logic                   error_reg;
    logic [ADDR_WIDTH-1:0]  stack_reg [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0]  addr_inc;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic [IDX_WIDTH-1:0]   push_idx;
    logic [IDX_WIDTH-1:0]   top_idx;
    mode_t                  mode;

    assign mode     = mode_t'(bus.ADDRSEQ_Mode_IN);
    assign addr_inc = addr_reg + 1'b1;
    assign full     = (depth_reg == DEPTH_MAX);
    assign empty    = (depth_reg == '0);
    assign push     = bus.ADDRSEQ_Enable_IN && (mode == MODE_CALL) && !full;
    // Indices are only used when the stack is not full (push) / not empty (pop).
    assign push_idx = IDX_WIDTH'(depth_reg);
    assign top_idx  = IDX_WIDTH'(depth_reg - 1'b1);

    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
            always_ff @(posedge ADDRSEQ_CLOCK_50) begin
                if (push && (push_idx == IDX_WIDTH'(gi))) begin
                    stack_reg[gi] <= addr_inc;
                end
            end
        end
    endgenerate

    always_ff @(posedge ADDRSEQ_CLOCK_50) begin
        if (ADDRSEQ_RESET_InHigh) begin
            addr_reg  <= RESET_ADDR;
            depth_reg <= '0;
            error_reg <= 1'b0;
        end else if (bus.ADDRSEQ_Enable_IN) begin
            case (mode)
                MODE_INC:  addr_reg <= addr_inc;
                MODE_JMP:  addr_reg <= bus.ADDRSEQ_Direccion_IN;
                MODE_JCT:  addr_reg <= bus.ADDRSEQ_Cond_IN ? bus.ADDRSEQ_Direccion_IN : addr_inc;
                MODE_JCF:  addr_reg <= !bus.ADDRSEQ_Cond_IN ? bus.ADDRSEQ_Direccion_IN : addr_inc;
                MODE_CALL: begin
                    if (full) begin
                        addr_reg  <= addr_inc;
                        error_reg <= 1'b1;
                    end else begin
                        addr_reg  <= bus.ADDRSEQ_Direccion_IN;
                        depth_reg <= depth_reg + 1'b1;
                    end
                end
                MODE_RET: begin
                    if (empty) begin
                        addr_reg  <= addr_inc;
                        error_reg <= 1'b1;
                    end else begin
                        addr_reg  <= stack_reg[top_idx];
                        depth_reg <= depth_reg - 1'b1;
                    end
                end
                MODE_HOLD: addr_reg <= addr_reg;
                MODE_RESTART: begin
                    addr_reg  <= RESET_ADDR;
                    depth_reg <= '0;
                end
                default: addr_reg <= addr_reg;
            endcase
        end
    end

    assign bus.ADDRSEQ_Direccion_OUT  = addr_reg;
    assign bus.ADDRSEQ_Depth_OUT      = depth_reg;
    assign bus.ADDRSEQ_StackFull_OUT  = full;
    assign bus.ADDRSEQ_StackEmpty_OUT = empty;
    assign bus.ADDRSEQ_Error_OUT      = error_reg;
endmodule

// File: tb/tb_address_sequencer.sv
// Directed bench for address_sequencer: one line per operation, immediate-assertion checks.
module tb_address_sequencer;
    localparam int AW = 11;
    localparam int SD = 4;
    localparam int DW = $clog2(SD + 1);

    localparam logic [2:0] INC = 3'd0, JMP = 3'd1, JCT = 3'd2, JCF = 3'd3,
                           CALL = 3'd4, RET = 3'd5, HOLD = 3'd6, RESTART = 3'd7;

    logic clk = 1'b0;
    logic srst;
    int   n_checks = 0;
    int   n_fail   = 0;

    address_sequencer_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) bus ();

    address_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .RESET_ADDR('0)) dut (
        .ADDRSEQ_CLOCK_50     (clk),
        .ADDRSEQ_RESET_InHigh (srst),
        .bus                  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one operation away from the edge, then sample 1 time unit after the edge.
    task automatic op(input logic rst, input logic en, input logic [2:0] mode,
                      input logic cond, input logic [AW-1:0] dir);
        @(negedge clk);
        srst                     = rst;
        bus.ADDRSEQ_Enable_IN    = en;
        bus.ADDRSEQ_Mode_IN      = mode;
        bus.ADDRSEQ_Cond_IN      = cond;
        bus.ADDRSEQ_Direccion_IN = dir;
        @(posedge clk);
        #1;
        $display("op rst=%0b en=%0b mode=%0d cond=%0b dir=%03h -> addr=%03h depth=%0d full=%0b empty=%0b err=%0b",
                 rst, en, mode, cond, dir, bus.ADDRSEQ_Direccion_OUT, bus.ADDRSEQ_Depth_OUT,
                 bus.ADDRSEQ_StackFull_OUT, bus.ADDRSEQ_StackEmpty_OUT, bus.ADDRSEQ_Error_OUT);
    endtask

    task automatic chk_state(input string tag, input logic [AW-1:0] a, input int d,
                             input logic err);
        chk({tag, "_addr"},  32'(bus.ADDRSEQ_Direccion_OUT), 32'(a));
        chk({tag, "_depth"}, 32'(bus.ADDRSEQ_Depth_OUT), 32'(d));
        chk({tag, "_full"},  32'(bus.ADDRSEQ_StackFull_OUT), 32'(d == SD));
        chk({tag, "_empty"}, 32'(bus.ADDRSEQ_StackEmpty_OUT), 32'(d == 0));
        chk({tag, "_err"},   32'(bus.ADDRSEQ_Error_OUT), 32'(err));
    endtask

    initial begin
        srst = 1'b1;
        bus.ADDRSEQ_Enable_IN = 1'b0;
        bus.ADDRSEQ_Mode_IN = INC;
        bus.ADDRSEQ_Cond_IN = 1'b0;
        bus.ADDRSEQ_Direccion_IN = '0;

        op(1, 0, INC, 0, 11'h000);
        op(1, 1, JMP, 0, 11'h123);                  chk_state("reset", 11'h000, 0, 0);

        op(0, 1, INC, 0, 11'h000);                  chk_state("inc1", 11'h001, 0, 0);
        op(0, 1, INC, 0, 11'h000);                  chk_state("inc2", 11'h002, 0, 0);
        op(0, 1, INC, 0, 11'h000);                  chk_state("inc3", 11'h003, 0, 0);

        op(0, 1, JMP, 0, 11'h7FF);                  chk_state("jmp_max", 11'h7FF, 0, 0);
        op(0, 1, INC, 0, 11'h000);                  chk_state("wrap", 11'h000, 0, 0);

        op(0, 1, JMP, 0, 11'h005);                  chk_state("jmp5", 11'h005, 0, 0);
        op(0, 1, JCT, 0, 11'h100);                  chk_state("jct_c0", 11'h006, 0, 0);
        op(0, 1, JCT, 1, 11'h100);                  chk_state("jct_c1", 11'h100, 0, 0);
        op(0, 1, JCF, 1, 11'h200);                  chk_state("jcf_c1", 11'h101, 0, 0);
        op(0, 1, JCF, 0, 11'h200);                  chk_state("jcf_c0", 11'h200, 0, 0);
        op(0, 1, HOLD, 1, 11'h3AA);                 chk_state("hold", 11'h200, 0, 0);

        op(0, 1, JMP, 0, 11'h010);                  chk_state("jmp10", 11'h010, 0, 0);
        op(0, 1, CALL, 0, 11'h020);                 chk_state("call1", 11'h020, 1, 0);
        op(0, 1, CALL, 0, 11'h030);                 chk_state("call2", 11'h030, 2, 0);
        op(0, 1, CALL, 0, 11'h040);                 chk_state("call3", 11'h040, 3, 0);
        op(0, 1, CALL, 0, 11'h050);                 chk_state("call4", 11'h050, 4, 0);
        op(0, 1, CALL, 0, 11'h060);                 chk_state("call_full", 11'h051, 4, 1);
        op(0, 1, RET, 0, 11'h000);                  chk_state("ret1", 11'h041, 3, 1);
        op(0, 1, RET, 0, 11'h000);                  chk_state("ret2", 11'h031, 2, 1);
        op(0, 1, RET, 0, 11'h000);                  chk_state("ret3", 11'h021, 1, 1);
        op(0, 1, RET, 0, 11'h000);                  chk_state("ret4", 11'h011, 0, 1);

        op(1, 0, INC, 0, 11'h000);                  chk_state("rst_clr", 11'h000, 0, 0);
        op(0, 1, JMP, 0, 11'h011);                  chk_state("jmp11", 11'h011, 0, 0);
        op(0, 1, RET, 0, 11'h000);                  chk_state("ret_empty", 11'h012, 0, 1);
        op(0, 1, CALL, 0, 11'h0AB);                 chk_state("call_pre", 11'h0AB, 1, 1);
        op(0, 1, RESTART, 0, 11'h0AB);              chk_state("restart", 11'h000, 0, 1);
        op(1, 1, INC, 0, 11'h000);                  chk_state("rst_err", 11'h000, 0, 0);

        op(0, 1, JMP, 0, 11'h100);
        op(0, 1, CALL, 0, 11'h300);                 chk_state("b2b_call", 11'h300, 1, 0);
        op(0, 1, RET, 0, 11'h000);                  chk_state("b2b_ret", 11'h101, 0, 0);

        op(0, 1, JMP, 0, 11'h7FF);
        op(0, 1, CALL, 0, 11'h050);                 chk_state("call_wrap", 11'h050, 1, 0);
        op(0, 1, RET, 0, 11'h000);                  chk_state("ret_wrap", 11'h000, 0, 0);

        op(0, 1, JMP, 0, 11'h044);
        op(0, 1, CALL, 0, 11'h070);                 chk_state("pre_dis", 11'h070, 1, 0);
        for (int i = 0; i < 3; i++) begin
            op(0, 0, CALL, 1, 11'h155);             chk_state("disabled", 11'h070, 1, 0);
        end
        op(0, 1, RET, 0, 11'h000);                  chk_state("post_dis", 11'h045, 0, 0);
        op(0, 1, CALL, 0, 11'h0C0);
        op(1, 1, CALL, 0, 11'h0D0);                 chk_state("rst_call", 11'h000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
